// File: rtl/div_share_arbiter.sv
// Round-robin front end that time-shares one combinational divider between NREQ
// requesters, with registered operands, registered results and divide-by-zero handling.
module div_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_dbz
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic             found;
    logic             accept;

    // Two descending passes: ports above last_grant overwrite ports at or below it,
    // so the lowest-numbered port after last_grant wins, wrapping around.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        winner = '0;
        found  = |req_valid;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i <= int'(last_grant)) winner = IDW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i > int'(last_grant)) winner = IDW'(i);
        end
    end

    assign accept = (state == IDLE) && found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= IDW'(NREQ - 1);
            op_id         <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_dividend <= req_dividend[int'(winner)*WIDTH +: WIDTH];
                        op_divisor  <= req_divisor[int'(winner)*WIDTH +: WIDTH];
                        op_id       <= winner;
                        last_grant  <= winner;
                    end
                end
                CALC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id;
                    // A zero divisor makes the divider output meaningless, so substitute
                    // the all-ones quotient and pass the dividend through as remainder.
                    if (op_divisor == '0) begin
                        rsp_quotient  <= '1;
                        rsp_remainder <= op_dividend;
                        rsp_dbz       <= 1'b1;
                    end else begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dbz       <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign div_dividend = op_dividend;
    assign div_divisor  = op_divisor;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed and randomized checks of div_share_arbiter against hand-computed values
// and a small round-robin / divider reference model.
module tb_div_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_dividend;
    logic [15:0] req_divisor;
    logic [3:0]  div_dividend;
    logic [3:0]  div_divisor;
    logic [3:0]  div_quotient;
    logic [3:0]  div_remainder;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_quotient;
    logic [3:0]  rsp_remainder;
    logic        rsp_dbz;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int id;
        int q;
        int r;
        int dbz;
    } exp_t;

    exp_t        expq[$];
    logic [3:0]  pv;
    logic [3:0]  pa [4];
    logic [3:0]  pb [4];

    div_share_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz)
    );

    // Divider stand-in; its zero-divisor output is deliberate garbage.
    assign div_quotient  = (div_divisor == 4'd0) ? 4'h5 : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == 4'd0) ? 4'hA : div_dividend % div_divisor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int p, input logic [3:0] a, input logic [3:0] b);
        req_dividend[p*4 +: 4] = a;
        req_divisor[p*4 +: 4]  = b;
    endtask

    function automatic int rr(input logic [3:0] v, input int lg);
        for (int k = 1; k <= 4; k++) begin
            if (v[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    int        fair_order [5] = '{0, 1, 2, 3, 0};
    int        fair_q     [4] = '{4, 3, 3, 2};
    int        fair_r     [4] = '{2, 3, 1, 2};
    int        mstate, mlg, w, nxt;
    logic [3:0] exp_rdy;
    exp_t      e;

    initial begin
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
        req_dividend = '0; req_divisor = '0;

        // Reset state, with requests asserted to show grants are suppressed
        tick(); tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_quot", rsp_quotient, 0);
        chk("rst_rem", rsp_remainder, 0);
        chk("rst_dbz", rsp_dbz, 0);
        chk("rst_div_dividend", div_dividend, 0);
        chk("rst_div_divisor", div_divisor, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = 4'b0000;
        rst = 1'b0;
        tick();

        // Single request: 13 / 4
        set_op(0, 4'd13, 4'd4); req_valid = 4'b0001; rsp_ready = 1'b1;
        #1 chk("single_grant", req_ready, 4'b0001);
        tick(); req_valid = 4'b0000;
        #1 chk("single_calc_ready", req_ready, 0);
        chk("single_calc_valid", rsp_valid, 0);
        chk("single_div_dividend", div_dividend, 13);
        chk("single_div_divisor", div_divisor, 4);
        tick();
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_quot", rsp_quotient, 3);
        chk("single_rem", rsp_remainder, 1);
        chk("single_dbz", rsp_dbz, 0);
        tick();
        chk("single_done", rsp_valid, 0);

        // Divide by zero on requester 2
        set_op(2, 4'd9, 4'd0); req_valid = 4'b0100;
        #1 chk("dbz_grant", req_ready, 4'b0100);
        tick(); req_valid = 4'b0000;
        tick();
        chk("dbz_valid", rsp_valid, 1);
        chk("dbz_id", rsp_id, 2);
        chk("dbz_quot", rsp_quotient, 4'hF);
        chk("dbz_rem", rsp_remainder, 9);
        chk("dbz_flag", rsp_dbz, 1);
        tick();

        // Fairness from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_quot", rsp_quotient, 0);
        chk("rst2_dbz", rsp_dbz, 0);
        set_op(0, 4'd14, 4'd3); set_op(1, 4'd15, 4'd4);
        set_op(2, 4'd7, 4'd2);  set_op(3, 4'd12, 4'd5);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1 chk("fair_grant", req_ready, 4'b0001 << fair_order[n]);
            tick();
            chk("fair_calc_ready", req_ready, 0);
            tick();
            chk("fair_valid", rsp_valid, 1);
            chk("fair_id", rsp_id, fair_order[n]);
            chk("fair_quot", rsp_quotient, fair_q[fair_order[n]]);
            chk("fair_rem", rsp_remainder, fair_r[fair_order[n]]);
            tick();
        end

        // Backpressure: 11 / 3 on requester 1, consumer stalls for 5 cycles
        set_op(1, 4'd11, 4'd3); req_valid = 4'b0010;
        #1 chk("bp_grant", req_ready, 4'b0010);
        tick(); req_valid = 4'b1111; rsp_ready = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 1);
            chk("bp_quot", rsp_quotient, 3);
            chk("bp_rem", rsp_remainder, 2);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_valid", rsp_valid, 1);
        tick();
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_hold_quot", rsp_quotient, 3);
        chk("bp_next_grant", req_ready, 4'b0100);
        req_valid = 4'b0000;
        tick();

        // Reset during CALC of requester 1 (15 / 2)
        set_op(1, 4'd15, 4'd2); req_valid = 4'b0010;
        #1 chk("rmid_grant", req_ready, 4'b0010);
        tick(); req_valid = 4'b0000;
        chk("rmid_div_dividend", div_dividend, 15);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rmid_valid0", rsp_valid, 0);
        chk("rmid_quot", rsp_quotient, 0);
        chk("rmid_div_dividend_rst", div_dividend, 0);
        tick(); chk("rmid_valid1", rsp_valid, 0);
        tick(); chk("rmid_valid2", rsp_valid, 0);
        req_valid = 4'b1010;
        #1 chk("rmid_after_grant", req_ready, 4'b0010);
        req_valid = 4'b0000;
        tick();

        // Random traffic against the reference model; last 50 cycles drain
        pv = '0; mlg = 3; mstate = 0;
        for (int cyc = 0; cyc < 250; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && cyc < 200 && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pb[i] = 4'($urandom_range(0, 15));
                end
                set_op(i, pa[i], pb[i]);
            end
            req_valid = pv;
            rsp_ready = (cyc < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            w = rr(pv, mlg);
            exp_rdy = (mstate == 0 && w >= 0) ? (4'b0001 << w) : 4'b0000;
            chk("rnd_req_ready", req_ready, exp_rdy);
            nxt = mstate;
            case (mstate)
                0: begin
                    chk("rnd_idle_valid", rsp_valid, 0);
                    if (w >= 0) begin
                        e.id  = w;
                        e.dbz = (pb[w] == 0) ? 1 : 0;
                        e.q   = (pb[w] == 0) ? 15 : int'(pa[w]) / int'(pb[w]);
                        e.r   = (pb[w] == 0) ? int'(pa[w]) : int'(pa[w]) % int'(pb[w]);
                        expq.push_back(e);
                        pv[w] = 1'b0;
                        mlg = w;
                        nxt = 1;
                    end
                end
                1: begin
                    chk("rnd_calc_valid", rsp_valid, 0);
                    nxt = 2;
                end
                default: begin
                    chk("rnd_resp_valid", rsp_valid, 1);
                    if (rsp_ready) begin
                        chk("rnd_queue_nonempty", (expq.size() > 0) ? 1 : 0, 1);
                        if (expq.size() > 0) begin
                            e = expq.pop_front();
                            chk("rnd_id", rsp_id, e.id);
                            chk("rnd_quot", rsp_quotient, e.q);
                            chk("rnd_rem", rsp_remainder, e.r);
                            chk("rnd_dbz", rsp_dbz, e.dbz);
                        end
                        nxt = 0;
                    end
                end
            endcase
            mstate = nxt;
            tick();
        end
        chk("rnd_drain_queue", expq.size(), 0);
        chk("rnd_drain_pending", pv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one combinational 4-bit divider (quotient, remainder, dividend, divisor) between NREQ requesters.
- Round-robin arbitration. Valid/ready request and response handshakes.
- Registered operands and registered results. Divide-by-zero detection.
- Sits between client blocks and the single divider instance; the divider itself stays purely combinational.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width; must match the divider instance.
- IDW, 2, width of requester ID; must be >= clog2(NREQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- req_dividend  in  NREQ*WIDTH  packed dividends; requester i uses bits [i*WIDTH +: WIDTH].
- req_divisor  in  NREQ*WIDTH  packed divisors, same packing.
- div_dividend  out  WIDTH  operand to shared divider.
- div_divisor  out  WIDTH  operand to shared divider.
- div_quotient  in  WIDTH  result from shared divider.
- div_remainder  in  WIDTH  result from shared divider.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of requester that owns the response.
- rsp_quotient  out  WIDTH  registered quotient.
- rsp_remainder  out  WIDTH  registered remainder.
- rsp_dbz  out  1  divide-by-zero flag for this response.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0.
  - Operand registers 0, so div_dividend=div_divisor=0.
  - last_grant=NREQ-1, so requester 0 has top priority after reset.
  - req_ready=0 while rst is high.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... wrapping modulo NREQ.
  - req_ready[winner]=1, combinational from req_valid and last_grant. All other req_ready bits are 0. No valid request -> req_ready=0.
  - On handshake (req_valid[w] & req_ready[w]): latch dividend, divisor and id=w into operand registers; last_grant<=w; go to CALC.
- CALC (exactly 1 cycle):
  - div_dividend/div_divisor are driven only from the operand registers, never from request inputs.
  - At the end of the cycle: rsp_quotient<=div_quotient, rsp_remainder<=div_remainder, rsp_id<=id, rsp_dbz<=0, rsp_valid<=1; go to RESP.
  - If the latched divisor==0, divider outputs are ignored: rsp_quotient<={WIDTH{1'b1}}, rsp_remainder<=dividend, rsp_dbz<=1.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0 and go to IDLE. Response fields keep their last values.
  - req_ready=0 throughout CALC and RESP.
- Latency and throughput:
  - Handshake at edge N -> rsp_valid high after edge N+1.
  - With rsp_ready tied high, rsp_valid is high for one cycle and next accept is possible at edge N+3, so minimum 3 cycles per operation.
- Requesters must hold req_valid and operands until their req_ready handshake.
- Requesters must not make req_valid depend on req_ready.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others stay pending.
- Round robin: a continuously requesting port cannot be granted twice while another port is pending.
- rst mid-operation (CALC or RESP): the in-flight operation is discarded, no response is issued, and all outputs take their reset values on that edge.
- Arithmetic: no width extension. Results are exactly WIDTH bits. Division is unsigned.

Test Plan:
- Single request: req0 dividend=13, divisor=4, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, quotient=3, remainder=1, dbz=0.
- Divide by zero: req2 dividend=9, divisor=0 -> quotient=4'b1111, remainder=9, dbz=1, regardless of the divider model's output.
- Fairness: all four requesters held valid with distinct operands -> grants in order 0,1,2,3,0; each rsp_id matches its operands' result.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, req_ready=0 on all ports; rsp_ready=1 -> back to IDLE and next grant the cycle after.
- Reset mid-op: assert rst during CALC of req1 (dividend=15, divisor=2) -> rsp_valid never rises for it; after reset, req1 and req3 both valid -> req1 granted first (last_grant=NREQ-1 so the search starts at 0).
- Random: 200 random operand/requester/rsp_ready patterns checked against a reference model -> every accepted request gets exactly one correct response, in acceptance order.
